// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the Simon game controller, sequence generator
// and sequence display stage.
//   color_t        : LED colour encoding (GREEN=0, YELLOW=1, RED=2, BLUE=3)
//   speed_t        : playback speed, 0 slowest .. 3 fastest
//   MAX_LEN_DEFAULT: default sequence capacity in steps
//   *_BIT          : bit positions inside the 3-bit status vector
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    BLUE   = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    SPEED_SLOW   = 2'd0,
    SPEED_MEDIUM = 2'd1,
    SPEED_FAST   = 2'd2,
    SPEED_MAX    = 2'd3
  } speed_t;

  localparam int MAX_LEN_DEFAULT = 16;

  localparam int DONE_BIT = 2;
  localparam int BUSY_BIT = 1;
  localparam int ON_BIT   = 0;

  // One-hot LED drive for a colour: bit n lights colour n.
  function automatic logic [3:0] color_onehot(input color_t color);
    return 4'b0001 << color;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Down-counter that times one display phase. Loading value D makes the phase
// last D+1 cycles: the counter sits at zero (expired) during the last cycle.
// It saturates at zero and never wraps.
// Ports:
//   i_clk        : clock, rising edge
//   i_reset_n    : asynchronous active-low reset
//   i_load       : load strobe, takes priority over counting
//   i_load_value : value loaded on i_load (phase length minus one)
//   o_expired    : high while the counter is zero
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  output logic         o_expired
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values and the order of statements cannot change behaviour.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else if (i_load) begin
      count_q <= i_load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign o_expired = (count_q == '0);

endmodule

// File: rtl/sequence_display_module.sv
// -----------------------------------------------------------------------------
// sequence_display_module
// Playback stage of the Simon controller. On a start (i_enable high in IDLE)
// it latches the colour sequence, clamped length and speed, then plays the
// steps as timed ON/OFF LED pulses and reports busy/done/on on o_value.
// All outputs are registered from the current state, so they follow the state
// register by one clock.
//
// Parameters:
//   MAX_LEN        : sequence capacity in steps (2 bits per step)
//   BASE_ON_CYCLES : ON time at the slowest speed, must be >= 16
// Ports:
//   i_clk        : system clock, rising edge
//   i_reset_n    : asynchronous active-low reset
//   i_enable     : level, high while the controller wants playback
//   i_sequence   : packed colours, step k in bits [2k+1:2k]
//   i_length     : number of steps to play (clamped to MAX_LEN)
//   i_speed      : 0 slowest .. 3 fastest; on = BASE_ON_CYCLES >> speed,
//                  off = on >> 1
//   o_led_color  : one-hot LED drive
//   o_value      : status {done, busy, led_on}
//
// Build option:
//   SEQ_DISPLAY_LEAD_IN_EN : when defined, a start first spends `off` cycles
//   in a dark, busy lead-in state before the first step (also before done
//   for length 0).
// -----------------------------------------------------------------------------
module sequence_display_module
  import game_pkg::*;
#(
  parameter int MAX_LEN        = MAX_LEN_DEFAULT,
  parameter int BASE_ON_CYCLES = 60_000_000
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_enable,
  input  logic [2*MAX_LEN-1:0]         i_sequence,
  input  logic [$clog2(MAX_LEN+1)-1:0] i_length,
  input  logic [1:0]                   i_speed,
  output logic [3:0]                   o_led_color,
  output logic [2:0]                   o_value
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = $clog2(BASE_ON_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef SEQ_DISPLAY_LEAD_IN_EN
    S_LEAD,
`endif
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  // Timer load values are phase length minus one.
  function automatic logic [TW-1:0] on_load(input logic [1:0] speed);
    return TW'((BASE_ON_CYCLES >> speed) - 1);
  endfunction

  function automatic logic [TW-1:0] off_load(input logic [1:0] speed);
    return TW'(((BASE_ON_CYCLES >> speed) >> 1) - 1);
  endfunction

  state_t                 state_q, state_d;
  logic [2*MAX_LEN-1:0]   seq_q;
  logic [LW-1:0]          len_q;
  speed_t                 speed_q;
  logic [IW-1:0]          idx_q;

  logic                   start;
  logic                   idx_inc;
  logic                   tmr_load;
  logic [TW-1:0]          tmr_value;
  logic                   tmr_expired;
  logic [LW-1:0]          len_clamped;
  logic                   last_step;
  color_t                 step_color;
  logic [3:0]             led_d;
  logic [2:0]             value_d;

  assign len_clamped = (i_length > LW'(MAX_LEN)) ? LW'(MAX_LEN) : i_length;
  assign last_step   = (LW'(idx_q) == len_q - LW'(1));
  assign step_color  = color_t'(seq_q[{idx_q, 1'b0} +: 2]);

  phase_timer #(
    .W (TW)
  ) u_phase_timer (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_load       (tmr_load),
    .i_load_value (tmr_value),
    .o_expired    (tmr_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    idx_inc   = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          start    = 1'b1;
          tmr_load = 1'b1;
`ifdef SEQ_DISPLAY_LEAD_IN_EN
          state_d   = S_LEAD;
          tmr_value = off_load(i_speed);
`else
          if (len_clamped == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_ON;
            tmr_value = on_load(i_speed);
          end
`endif
        end
      end
`ifdef SEQ_DISPLAY_LEAD_IN_EN
      S_LEAD: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if (tmr_expired) begin
          if (len_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_ON;
            tmr_load  = 1'b1;
            tmr_value = on_load(speed_q);
          end
        end
      end
`endif
      S_ON: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if (tmr_expired) begin
          state_d   = S_OFF;
          tmr_load  = 1'b1;
          tmr_value = off_load(speed_q);
        end
      end
      S_OFF: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if (tmr_expired) begin
          if (last_step) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_ON;
            idx_inc   = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = on_load(speed_q);
          end
        end
      end
      S_DONE: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the latched sequence is a plain register bank, not a RAM, so it is
  // reset along with everything else to keep outputs free of X after reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seq_q   <= '0;
      len_q   <= '0;
      speed_q <= SPEED_SLOW;
      idx_q   <= '0;
    end else if (start) begin
      seq_q   <= i_sequence;
      len_q   <= len_clamped;
      speed_q <= speed_t'(i_speed);
      idx_q   <= '0;
    end else if (idx_inc) begin
      idx_q   <= idx_q + IW'(1);
    end
  end

  // Output decode from the current state; registered below.
  always_comb begin
    led_d   = '0;
    value_d = '0;
    case (state_q)
`ifdef SEQ_DISPLAY_LEAD_IN_EN
      S_LEAD: value_d[BUSY_BIT] = 1'b1;
`endif
      S_ON: begin
        led_d             = color_onehot(step_color);
        value_d[BUSY_BIT] = 1'b1;
        value_d[ON_BIT]   = 1'b1;
      end
      S_OFF:  value_d[BUSY_BIT] = 1'b1;
      S_DONE: value_d[DONE_BIT] = 1'b1;
      default: begin
        led_d   = '0;
        value_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_led_color <= '0;
      o_value     <= '0;
    end else begin
      o_led_color <= led_d;
      o_value     <= value_d;
    end
  end

endmodule

// File: tb/tb_sequence_display_module.sv
// -----------------------------------------------------------------------------
// tb_sequence_display_module
// Directed bench for sequence_display_module with BASE_ON_CYCLES=16 and
// MAX_LEN=16 (lead-in option not defined). Edge 0 is the edge that samples a
// start; outputs are checked 1 time unit after every edge against a small
// timing model of the expected LED/status waveform.
// -----------------------------------------------------------------------------
module tb_sequence_display_module;

  localparam int MAX_LEN = 16;
  localparam int BASE    = 16;

  logic         i_clk = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_enable = 1'b0;
  logic [31:0]  i_sequence = '0;
  logic [4:0]   i_length = '0;
  logic [1:0]   i_speed = '0;
  logic [3:0]   o_led_color;
  logic [2:0]   o_value;

  int vectors = 0;
  int miscompares = 0;

  sequence_display_module #(
    .MAX_LEN        (MAX_LEN),
    .BASE_ON_CYCLES (BASE)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_enable    (i_enable),
    .i_sequence  (i_sequence),
    .i_length    (i_length),
    .i_speed     (i_speed),
    .o_led_color (o_led_color),
    .o_value     (o_value)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] led_exp,
                       input logic [2:0] val_exp);
    vectors++;
    assert (o_led_color === led_exp && o_value === val_exp) else begin
      miscompares++;
      $error("FAIL %s: led=%b value=%b, expected led=%b value=%b",
             tag, o_led_color, o_value, led_exp, val_exp);
    end
  endtask

  // Expected {led[3:0], value[2:0]} after edge e of a playback started at edge 0.
  function automatic logic [6:0] model(input int e, input logic [31:0] seq,
                                       input int len, input int spd);
    int on, off, per, k, r;
    logic [1:0] col;
    on  = BASE >> spd;
    off = on >> 1;
    per = on + off;
    if (e <= 0) return 7'b0;
    if (e >= len * per + 1) return {4'b0000, 3'b100};
    k = (e - 1) / per;
    r = (e - 1) % per;
    if (r < on) begin
      col = seq[2*k +: 2];
      return {4'b0001 << col, 3'b011};
    end
    return {4'b0000, 3'b010};
  endfunction

  // Start a playback and check edges 0..last_edge. Inputs are scrambled after
  // edge 3 to show they are ignored once latched. Enable is left high.
  task automatic play(input string name, input logic [31:0] seq,
                      input logic [4:0] len, input logic [1:0] spd,
                      input int eff_len, input int last_edge);
    logic [6:0] exp;
    i_sequence = seq;
    i_length   = len;
    i_speed    = spd;
    i_enable   = 1'b1;
    for (int e = 0; e <= last_edge; e++) begin
      tick();
      exp = model(e, seq, eff_len, int'(spd));
      check($sformatf("%s_e%0d", name, e), exp[6:3], exp[2:0]);
      if (e == 3) begin
        i_sequence = ~seq;
        i_length   = 5'd1;
        i_speed    = spd ^ 2'd3;
      end
    end
  endtask

  // Drop enable; status must be all zero one edge after it is sampled.
  task automatic stop(input string name);
    i_enable = 1'b0;
    tick();
    tick();
    check(name, 4'b0000, 3'b000);
  endtask

  initial begin
    // Reset state
    #3;
    check("reset_held", 4'b0000, 3'b000);
    #9 i_reset_n = 1'b1;
    tick();
    check("idle_after_reset", 4'b0000, 3'b000);

    // Speed 0, length 3: Blue, Green, Red; done at edge 73
    play("c1", 32'h0000_0023, 5'd3, 2'd0, 3, 76);
    stop("c1_stop");

    // Speed 3, length 16, alternating Green/Yellow; done at edge 49
    play("c2", 32'h4444_4444, 5'd16, 2'd3, 16, 51);
    stop("c2_stop");

    // Length 0: done at edge 1, LEDs dark
    play("c3", 32'hFFFF_FFFF, 5'd0, 2'd1, 0, 4);
    stop("c3_stop");

    // Abort at edge 20, restart at edge 23 replays from step 0
    play("c4", 32'h0000_0023, 5'd3, 2'd0, 3, 19);
    i_enable = 1'b0;
    tick();
    check("c4_e20", 4'b0000, 3'b010);
    tick();
    check("c4_e21_abort", 4'b0000, 3'b000);
    tick();
    play("c4_restart", 32'h0000_0023, 5'd3, 2'd0, 3, 76);
    stop("c4_stop");

    // Asynchronous reset in the middle of an ON phase
    play("c5", 32'h0000_0023, 5'd3, 2'd0, 3, 5);
    #2;
    i_reset_n = 1'b0;
    i_enable  = 1'b0;
    #1;
    check("c5_async_clear", 4'b0000, 3'b000);
    @(posedge i_clk);
    #1;
    check("c5_reset_held", 4'b0000, 3'b000);
    #3 i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("c5_recovered", 4'b0000, 3'b000);
    play("c5_restart", 32'h4444_4444, 5'd16, 2'd3, 16, 50);
    stop("c5_stop");

    // Length 20 clamped to 16, all four colours, inputs scrambled mid-play
    play("c6", 32'hE4E4_E4E4, 5'd20, 2'd3, 16, 52);
    stop("c6_stop");

    // Length 2 at speed 2 (on=4, off=2): done at edge 13
    play("c7", 32'h0000_000E, 5'd2, 2'd2, 2, 15);
    stop("c7_stop");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
